// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder slice.
// Imported by the interface, the read pipe and the responder top.
package dmem_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 32;
    localparam int CNT_W  = 16;

    typedef logic [DATA_W-1:0] word_t;
    typedef logic [CNT_W-1:0]  cnt_t;

    localparam word_t POISON_DEFAULT = 32'hDEAD_BEEF;

    typedef struct packed {
        logic  valid;
        word_t data;
    } rd_stage_t;

    // A store wins when both enables are high.
    typedef enum logic [1:0] {
        REQ_IDLE,
        REQ_LOAD,
        REQ_STORE
    } req_kind_t;

endpackage

// File: rtl/dmem_responder_if.sv
// Request and status signals between the CPU data port and the responder.
// The bidirectional data bus stays a plain port on the responder.
interface dmem_responder_if;
    import dmem_pkg::*;

    logic              dmem_wen;
    logic              dmem_ren;
    logic [ADDR_W-1:0] dmem_addr;
    logic              rdata_valid;
    logic              misalign_err;
    logic              range_err;
    logic              proto_err;
    cnt_t              rd_count;
    cnt_t              wr_count;

    modport master (
        output dmem_wen, dmem_ren, dmem_addr,
        input  rdata_valid, misalign_err, range_err, proto_err, rd_count, wr_count
    );

    modport slave (
        input  dmem_wen, dmem_ren, dmem_addr,
        output rdata_valid, misalign_err, range_err, proto_err, rd_count, wr_count
    );

endinterface

// File: rtl/dmem_rd_pipe.sv
// RD_LAT-deep delay line of {valid, data} read stages.
// Only the valid bits clear on reset, so in-flight loads are dropped.
module dmem_rd_pipe
    import dmem_pkg::*;
#(
    parameter int RD_LAT = 1
) (
    input  logic      clk,
    input  logic      rst_n,
    input  rd_stage_t in_stage,
    output rd_stage_t out_stage
);

    logic [RD_LAT-1:0] valid_q;
    word_t             data_q [RD_LAT];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= '0;
        end else begin
            valid_q[0] <= in_stage.valid;
            for (int i = 1; i < RD_LAT; i++) begin
                valid_q[i] <= valid_q[i-1];
            end
        end
    end

    // NOTE: data stages and the memory array carry no reset; valid qualifies them.
    always_ff @(posedge clk) begin
        data_q[0] <= in_stage.data;
        for (int i = 1; i < RD_LAT; i++) begin
            data_q[i] <= data_q[i-1];
        end
    end

    assign out_stage.valid = valid_q[RD_LAT-1];
    assign out_stage.data  = data_q[RD_LAT-1];

endmodule

// File: rtl/dmem_responder.sv
// Word-addressed data memory on the CPU dmem port: stores, pipelined loads,
// tri-state read return, error pulses and traffic counters.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int    DEPTH  = 1024,
    parameter int    RD_LAT = 1,
    parameter word_t POISON = POISON_DEFAULT
) (
    input  logic                clk,
    input  logic                rst_n,
    dmem_responder_if.slave     dmem,
    inout  tri   [DATA_W-1:0]   dmem_data
);

    localparam int IDX_W = $clog2(DEPTH);

    word_t             mem [DEPTH];
    req_kind_t         kind;
    logic [ADDR_W-3:0] word_idx;
    logic [IDX_W-1:0]  idx;
    logic              aligned;
    logic              in_range;
    rd_stage_t         pipe_in;
    rd_stage_t         pipe_out;
    logic              drive;
    logic              conflict;

    logic              misalign_q;
    logic              range_q;
    logic              proto_q;
    cnt_t              rd_count_q;
    cnt_t              wr_count_q;

    assign word_idx = dmem.dmem_addr[ADDR_W-1:2];
    assign idx      = word_idx[IDX_W-1:0];
    assign aligned  = (dmem.dmem_addr[1:0] == 2'b00);
    assign in_range = (word_idx < (ADDR_W-2)'(DEPTH));

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        kind = REQ_IDLE;
        if (dmem.dmem_wen) begin
            kind = REQ_STORE;
        end else if (dmem.dmem_ren) begin
            kind = REQ_LOAD;
        end
    end

    always_comb begin
        pipe_in = '0;
        if (kind == REQ_LOAD && aligned) begin
            pipe_in.valid = 1'b1;
            pipe_in.data  = in_range ? mem[idx] : POISON;
        end
    end

    // NOTE: the write is non-blocking, so a load sampled on the same edge
    // still captures the old word (read-before-write).
    always_ff @(posedge clk) begin
        if (rst_n && kind == REQ_STORE && aligned && in_range) begin
            mem[idx] <= dmem_data;
        end
    end

    dmem_rd_pipe #(
        .RD_LAT (RD_LAT)
    ) u_rd_pipe (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_stage  (pipe_in),
        .out_stage (pipe_out)
    );

    // A store arriving while load data is due owns the bus; that load is lost.
    assign drive    = pipe_out.valid && !dmem.dmem_wen;
    assign conflict = pipe_out.valid &&  dmem.dmem_wen;

    assign dmem_data = drive ? pipe_out.data : 'z;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            misalign_q <= 1'b0;
            range_q    <= 1'b0;
            proto_q    <= 1'b0;
            rd_count_q <= '0;
            wr_count_q <= '0;
        end else begin
            misalign_q <= (kind != REQ_IDLE) && !aligned;
            range_q    <= (kind != REQ_IDLE) && aligned && !in_range;
            proto_q    <= (dmem.dmem_wen && dmem.dmem_ren) || conflict;
            if (kind == REQ_LOAD && aligned) begin
                rd_count_q <= rd_count_q + cnt_t'(1);
            end
            if (kind == REQ_STORE && aligned && in_range) begin
                wr_count_q <= wr_count_q + cnt_t'(1);
            end
        end
    end

    assign dmem.rdata_valid  = drive;
    assign dmem.misalign_err = misalign_q;
    assign dmem.range_err    = range_q;
    assign dmem.proto_err    = proto_q;
    assign dmem.rd_count     = rd_count_q;
    assign dmem.wr_count     = wr_count_q;

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Word-addressed data-memory responder on the far end of the CPU's `dmem_*` port. It accepts stores, returns loads after a fixed, parameterised latency, and owns its half of the bidirectional `dmem_data` bus. It also flags illegal accesses and counts traffic. It sits beside the CPU in the top-level testbench/SoC wrapper, in the slot currently left open by the CPU's data-memory port.

## Interface
- `DEPTH`, 1024 — number of 32-bit words stored; power of two, 16–65536.
- `RD_LAT`, 1 — read latency in cycles from request sample to data on bus; legal 1–3.
- `POISON`, 32'hDEAD_BEEF — data returned for out-of-range reads.
- `clk`  in  1  — single clock; all logic on posedge.
- `rst_n`  in  1  — reset, synchronous, active-low.
- `dmem_wen`  in  1  — 1 = store this cycle (CPU drives `dmem_data`).
- `dmem_ren`  in  1  — 1 = load request this cycle; new signal the CPU adds (it already computes MemRead).
- `dmem_addr`  in  32  — byte address; word index = `dmem_addr[31:2]`.
- `dmem_data`  inout  32  — store data in; load data out when driving; else `'z`.
- `rdata_valid`  out  1  — high in the cycle this block drives valid load data.
- `misalign_err`  out  1  — 1-cycle pulse: request with `dmem_addr[1:0] != 0`.
- `range_err`  out  1  — 1-cycle pulse: word index ≥ DEPTH.
- `proto_err`  out  1  — 1-cycle pulse: `dmem_wen && dmem_ren`, or bus conflict.
- `rd_count`, `wr_count`  out  16 each  — accepted loads/stores; wrap at 16'hFFFF→0.

## Operation
- A request is sampled at posedge when `dmem_wen` or `dmem_ren` is high. An idle cycle has neither high.
- Store, aligned and in range: `mem[idx] <= dmem_data`. Increment `wr_count`.
- Load, aligned and in range: read `mem[idx]` and push it into the read pipe. Increment `rd_count`.
- Out-of-range load: push POISON and pulse `range_err`. It counts in `rd_count`.
- Out-of-range store: drop it. Pulse `range_err`. No count.
- Misaligned load or store: drop it, push nothing, pulse `misalign_err`. No count. Misaligned takes priority over range.
- `dmem_wen && dmem_ren`: treat as the store only; discard the load and pulse `proto_err`.
- Same-cycle store and earlier-load collision on one address: the array is read-before-write. A load sampled in cycle N sees stores from cycles < N only.
- Read pipe: RD_LAT stages of {valid, data}. The stage-RD_LAT output is the drive candidate.
- Bus drive: `drive = pipe_valid_out && !dmem_wen`. `dmem_data = drive ? pipe_data_out : 'z`. `rdata_valid = drive`.
- Conflict: if `pipe_valid_out && dmem_wen`, release the bus, drop that load data, and pulse `proto_err`. The store still executes.
- Error pulses are registered. They assert in the cycle after the offending sample and last exactly one cycle. Back-to-back offending cycles give back-to-back high.
- Memory contents are not reset and power up as X. The bench preloads via hierarchical `$readmemh`.

## Timing
- Load sampled at edge N: data on bus and `rdata_valid` high during cycle N+RD_LAT−1→N+RD_LAT, i.e. after edge N+RD_LAT−1. For RD_LAT=1 it is valid the whole cycle following edge N.
- Loads are fully pipelined: one per cycle, no stalls, no backpressure.
- Store takes effect at edge N. A load sampled at N+1 returns the new value.
- Counters update at the sampling edge and are visible after it.
- Reset (rst_n low at a posedge) has the following effect:
  - All pipe valids clear, so pending loads are lost.
  - `rdata_valid`, `misalign_err`, `range_err`, `proto_err` = 0.
  - `rd_count` = `wr_count` = 0.
  - Bus is `'z` from the following cycle.
  - Requests sampled while `rst_n` is low are ignored; the memory array is untouched.
- Reset mid-operation: a store sampled at the same edge as reset is ignored.

## Structure
- Package `dmem_pkg` holds:
  - `DATA_W`=32, `ADDR_W`=32, `CNT_W`=16.
  - typedef `word_t`.
  - typedef `rd_stage_t` (struct {valid, data}).
  - POISON default.
- Sub-module `dmem_rd_pipe`: parameterised RD_LAT-deep delay line of `rd_stage_t` with synchronous clear. The top holds the array, request decode, error logic, counters and tri-state.

## Test plan
- Store 32'h1234_5678 @0x40 at edge 0; load 0x40 at edge 1, RD_LAT=1 → bus=32'h1234_5678, `rdata_valid`=1 after edge 1 only; `wr_count`=1, `rd_count`=1.
- RD_LAT=3, loads 0x0,0x4,0x8 back-to-back (preloaded 1,2,3) → bus 1,2,3 on three consecutive cycles starting after edge 2 of the first load's sample +2; no gaps.
- Load 0x42 → no drive, `misalign_err` one-cycle pulse, counters unchanged; store 4*DEPTH → `range_err` pulse, no write; load 4*DEPTH → POISON returned.
- `dmem_wen`=`dmem_ren`=1 @0x10 with data 32'hA5A5 → mem[4]=32'hA5A5, no load data, `proto_err` pulse; separately, store issued in the cycle a load is due → bus not driven, `proto_err` pulse.
- Issue load with RD_LAT=2, assert rst_n=0 at next edge → `rdata_valid` never asserts, bus 'z, counters 0; contents of earlier stores intact after reset.
- 65536 loads → `rd_count` wraps to 0.
